// File: rtl/alu_mc_if.sv
// rtl/alu_mc_if.sv - request/response handshake bundle for the multi-cycle ALU
//
// Purpose: groups the request channel (in_valid/in_ready, alucontrol, a, b)
//          and the response channel (out_valid/out_ready, result, zero,
//          overflow) of alu_mc.
// Modports:
//   master - requester/consumer side: drives requests and out_ready
//   slave  - ALU side: drives in_ready and the response
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alucontrol;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;

  modport master (
    output in_valid, alucontrol, a, b, out_ready,
    input  in_ready, out_valid, result, zero, overflow
  );

  modport slave (
    input  in_valid, alucontrol, a, b, out_ready,
    output in_ready, out_valid, result, zero, overflow
  );
endinterface

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with shift-add multiplier and valid/ready handshake
//
// Purpose: single-issue ALU. Logic/add/sub/slt complete one cycle after
//          accept; mul iterates one multiplier bit per cycle for WIDTH
//          cycles. The result is held until the consumer takes it.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - alu_mc_if.slave: in_valid/in_ready, alucontrol, a, b,
//          out_valid/out_ready, result, zero, overflow
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  alu_mc_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             accept;
  logic             mul_last;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] result_q;
  logic             overflow_q;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;

  assign accept   = bus.in_valid && (state == IDLE);
  assign mul_last = (cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = (bus.alucontrol == OP_MUL) ? MUL : DONE;
        end
      end
      MUL: begin
        if (mul_last) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE:    bus.in_ready  = 1'b1;
      DONE:    bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  // Single-cycle operations, evaluated on the operands being captured at accept
  assign sum  = bus.a + bus.b;
  assign diff = bus.a - bus.b;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.alucontrol)
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_XOR: alu_res = bus.a ^ bus.b;
      OP_NOR: alu_res = ~(bus.a | bus.b);
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                  (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                  (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      default: alu_res = '0;
    endcase
  end

  // One shift-add step: multiplicand moves left, multiplier moves right, so
  // bit 0 of mplier always selects whether the current mcand is added.
  assign acc_nx = acc + (mplier[0] ? mcand : '0);

  // Datapath: operand capture, multiplier iteration, result holding.
  // result_q and overflow_q only change on accept or on the last mul step,
  // so they stay stable through DONE regardless of input activity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mcand  <= bus.a;
            mplier <= bus.b;
            acc    <= '0;
            cnt    <= '0;
            if (bus.alucontrol != OP_MUL) begin
              result_q   <= alu_res;
              overflow_q <= alu_ovf;
            end
          end
        end
        MUL: begin
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (mul_last) begin
            result_q   <= acc_nx;
            overflow_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result   = result_q;
  assign bus.zero     = (result_q == '0);
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - directed self-checking bench for alu_mc
module tb_alu_mc;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  alu_mc_if #(.WIDTH(32)) bus ();

  alu_mc #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op with out_ready=1, scramble operands after accept, and
  // return the captured response plus latency in cycles from accept.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic z,
                        output logic ov, output int lat);
    int guard;
    @(negedge clk);
    bus.alucontrol = op;
    bus.a          = a;
    bus.b          = b;
    bus.in_valid   = 1'b1;
    bus.out_ready  = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_in_ready"}, bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid   = 1'b0;
    bus.a          = ~a;
    bus.b          = ~b;
    bus.alucontrol = ~op;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    r  = bus.result;
    z  = bus.zero;
    ov = bus.overflow;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_valid_drop"}, bus.out_valid, 0);
  endtask

  initial begin
    logic [31:0] r;
    logic        z;
    logic        ov;
    int          lat;
    logic        bad;
    logic [31:0] held;

    n_checks       = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.alucontrol = 3'b000;
    bus.a          = '0;
    bus.b          = '0;
    bus.out_ready  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_zero", bus.zero, 1);
    check("rst_overflow", bus.overflow, 0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 1);

    // add with signed overflow
    run_op("add_ovf", 3'b010, 32'h7FFF_FFFF, 32'h0000_0001, r, z, ov, lat);
    check("add_lat", lat, 1);
    check("add_res", r, 32'h8000_0000);
    check("add_ovf", ov, 1);
    check("add_zero", z, 0);

    // sub to zero
    run_op("sub0", 3'b110, 32'd5, 32'd5, r, z, ov, lat);
    check("sub0_res", r, 0);
    check("sub0_zero", z, 1);
    check("sub0_ovf", ov, 0);

    // sub with signed overflow: most negative minus one
    run_op("sub_ovf", 3'b110, 32'h8000_0000, 32'h0000_0001, r, z, ov, lat);
    check("sub_ovf_res", r, 32'h7FFF_FFFF);
    check("sub_ovf_flag", ov, 1);

    // slt signed
    run_op("slt_t", 3'b111, 32'hFFFF_FFFF, 32'h0000_0001, r, z, ov, lat);
    check("slt_t_res", r, 1);
    run_op("slt_f", 3'b111, 32'h0000_0001, 32'hFFFF_FFFF, r, z, ov, lat);
    check("slt_f_res", r, 0);
    check("slt_f_zero", z, 1);

    // mul variants
    run_op("mul_ff", 3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, z, ov, lat);
    check("mul_ff_res", r, 32'h0000_0001);
    check("mul_ff_lat", lat, 33);
    run_op("mul_sh", 3'b100, 32'h1234_5678, 32'h0000_0010, r, z, ov, lat);
    check("mul_sh_res", r, 32'h2345_6780);
    check("mul_sh_ovf", ov, 0);

    // mul with in_valid held high and changing operands during MUL
    @(negedge clk);
    bus.alucontrol = 3'b100;
    bus.a          = 32'h0001_0001;
    bus.b          = 32'h0001_0001;
    bus.in_valid   = 1'b1;
    bus.out_ready  = 1'b1;
    check("mul_in_ready", bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.alucontrol = 3'b010;
    bus.a          = 32'd5;
    bus.b          = 32'd7;
    bad = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    bus.in_valid = 1'b0;
    check("mul_busy_ready", bad, 0);
    check("mul_lat", lat, 33);
    check("mul_res", bus.result, 32'h0002_0001);
    check("mul_ovf", bus.overflow, 0);
    @(posedge clk);
    @(negedge clk);
    check("mul_valid_drop", bus.out_valid, 0);

    // xor with consumer stalled for 5 cycles
    bus.alucontrol = 3'b011;
    bus.a          = 32'hF0F0_F0F0;
    bus.b          = 32'hFFFF_0000;
    bus.in_valid   = 1'b1;
    bus.out_ready  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = 32'h1234_5678;
    check("xor_valid", bus.out_valid, 1);
    check("xor_res", bus.result, 32'h0F0F_F0F0);
    held = bus.result;
    bad  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (!bus.out_valid || bus.result !== held || bus.in_ready) bad = 1'b1;
    end
    check("xor_hold", bad, 0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("xor_idle_valid", bus.out_valid, 0);
    check("xor_idle_ready", bus.in_ready, 1);

    // reset in the middle of a multiply
    check("pre_rst_result", bus.result, 32'h0F0F_F0F0);
    bus.alucontrol = 3'b100;
    bus.a          = 32'd3;
    bus.b          = 32'd5;
    bus.in_valid   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mrst_out_valid", bus.out_valid, 0);
    check("mrst_result", bus.result, 0);
    check("mrst_zero", bus.zero, 1);
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) bad = 1'b1;
    end
    check("mrst_no_result", bad, 0);
    run_op("or_after", 3'b001, 32'h0000_000F, 32'h0000_00F0, r, z, ov, lat);
    check("or_res", r, 32'h0000_00FF);
    check("or_lat", lat, 1);

    // back-to-back with in_valid held high
    @(negedge clk);
    bus.alucontrol = 3'b000;
    bus.a          = 32'h0000_00AA;
    bus.b          = 32'h0000_0055;
    bus.in_valid   = 1'b1;
    bus.out_ready  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.alucontrol = 3'b101;
    bus.a          = 32'h0000_00F0;
    bus.b          = 32'h0000_000F;
    check("b2b_and_valid", bus.out_valid, 1);
    check("b2b_and_res", bus.result, 0);
    check("b2b_and_zero", bus.zero, 1);
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.in_ready || bus.result !== 32'h0) bad = 1'b1;
    end
    check("b2b_not_accepted", bad, 0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("b2b_gap_valid", bus.out_valid, 0);
    check("b2b_gap_ready", bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("b2b_nor_valid", bus.out_valid, 1);
    check("b2b_nor_res", bus.result, 32'hFFFF_FF00);
    @(posedge clk);
    @(negedge clk);
    check("b2b_end_valid", bus.out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
